alu_result_pipe: RTL and testbench
==================================

// Module: alu_result_pipe
// PURPOSE
//  Parametrised, elastic ALU result register: DEPTH-stage valid/ready pipeline carrying WIDTH-bit results.
//  Sits between the ALU and the writeback/memory-address logic.
//  Adds over a plain result register: back-pressure, bubble collapsing, synchronous flush, occupancy count.
// PARAMETERS
//  WIDTH  32  result data width in bits (>=1)
//  DEPTH  2   number of register stages (>=1); latency in cycles when not stalled
//  CNT_W  $clog2(DEPTH+1)  width of Count (localparam, derived, not overridable)
// PORTS
//  Clk         in   1        clock; all state updates on rising edge
//  Reset       in   1        asynchronous, active-low reset (0 = reset)
//  Flush       in   1        synchronous flush; discards all in-flight results
//  In_Valid    in   1        ALUResult valid this cycle
//  In_Ready    out  1        pipe accepts ALUResult this cycle
//  ALUResult   in   WIDTH    result from ALU
//  Out_Valid   out  1        Result valid (last stage occupied)
//  Out_Ready   in   1        consumer takes Result this cycle
//  Result      out  WIDTH    last-stage data
//  Result_Zero out  1        1 when Result == 0 (combinational from last stage)
//  Count       out  CNT_W    number of occupied stages, 0..DEPTH
// BEHAVIOUR
//  Reset low (async): all stage valids=0, all stage data=0, Count=0, Out_Valid=0, Result=0.
//  Result_Zero therefore reads 1 while Reset is low; In_Ready=0 while Reset is low.
//  Stage i = 0..DEPTH-1; stage DEPTH-1 drives Result and Out_Valid.
//  rdy[DEPTH-1] = !v[DEPTH-1] | Out_Ready; rdy[i] = !v[i] | rdy[i+1].
//  In_Ready = rdy[0] & !Flush.
//  Transfer in:  In_Valid & In_Ready. Transfer out: Out_Valid & Out_Ready.
//  Stage i load (rdy[i]=1): data[i] <= upstream data, v[i] <= upstream valid.
//    Upstream of stage 0 is ALUResult / In_Valid & !Flush.
//  Stage i hold (rdy[i]=0): data and valid unchanged.
//  Data of a stage loaded with valid=0 is don't-care; implement as hold to save power.
//  Bubbles collapse: an empty stage always loads, so a stalled output does not block upstream stages until all DEPTH are full.
//  Latency: a result accepted at edge N appears on Result after edge N+DEPTH-1 (visible in cycle N+DEPTH) if Out_Ready=1 throughout.
//  Throughput: 1 result/cycle when Out_Ready=1.
//  Full (Count==DEPTH) & Out_Ready=0: In_Ready=0, no state change.
//  Full & Out_Ready=1: simultaneous in and out; Count unchanged.
//  Empty: Out_Valid=0; Result holds last value.
//  Flush=1 at an edge:
//    - all v[i] <= 0; Count <= 0; data unchanged.
//    - Out_Ready that cycle is ignored; the consumer must not treat Result as taken.
//    - Flush overrides simultaneous transfers.
//  Count: +1 on transfer in, -1 on transfer out, both => unchanged, Flush => 0; never wraps.
//  Reset asserted mid-stream: immediate clear of all state; no partial results on release.
//  No combinational path from In_Valid/ALUResult to outputs. Out_Ready->In_Ready is combinational (ready chain).
// TESTING
//  1. DEPTH=2, Out_Ready=1, push 0x11,0x22,0x33 back-to-back -> Result 0x11,0x22,0x33 in cycles 2,3,4 after first accept; Count peaks at 2.
//  2. DEPTH=3, Out_Ready=0, push 0xA,0xB,0xC,0xD -> 3 accepted, In_Ready=0 on 4th, Count=3; release Out_Ready -> 0xA,0xB,0xC out in order, then 0xD accepted.
//  3. Bubble collapse, DEPTH=3: one value in, Out_Ready=0 -> value reaches last stage after 2 cycles; In_Ready stays 1 until Count=3.
//  4. Full pipe + Flush=1 with In_Valid=1 and Out_Ready=1 -> next cycle Count=0, Out_Valid=0, In_Ready=0 during flush, no transfer counted.
//  5. Reset pulled low mid-stream (async, between edges) -> Out_Valid, Count, Result go 0 immediately; Result_Zero=1; resume clean after release.
//  6. WIDTH=8, DEPTH=1, random valid/ready for 10k cycles -> scoreboard: in-order, no loss or duplication; Count == model; Result_Zero == (Result==0).

Source files
------------

// File: rtl/alu_result_pipe.sv
// Elastic DEPTH-stage valid/ready register pipe for ALU results.
// Empty stages always load, so bubbles collapse under output stall.
module alu_result_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] ALUResult,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Result,
  output logic             Result_Zero,
  output logic [CNT_W-1:0] Count
);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [DEPTH-1:0]            rdy;
  logic                        in_xfer, out_xfer;

  // Ready chain: a stage can load if it is empty or its successor can load.
  always_comb begin
    logic chain;
    chain = Out_Ready;
    rdy   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = !v_q[i] | chain;
      rdy[i] = chain;
    end
  end

  assign In_Ready    = Reset & rdy[0] & !Flush;
  assign Out_Valid   = v_q[DEPTH-1];
  assign Result      = data_q[DEPTH-1];
  assign Result_Zero = (Result == '0);
  assign Count       = count_q;
  assign in_xfer     = In_Valid & In_Ready;
  assign out_xfer    = Out_Valid & Out_Ready;

  // Data only moves with a valid token; invalid loads keep the old value.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (Flush) begin
      v_d = '0;
    end else begin
      if (rdy[0]) begin
        v_d[0] = In_Valid;
        if (In_Valid) data_d[0] = ALUResult;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) data_d[i] = data_q[i-1];
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (Flush)                    count_d = '0;
    else if (in_xfer && !out_xfer) count_d = count_q + 1'b1;
    else if (!in_xfer && out_xfer) count_d = count_q - 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      v_q     <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_result_pipe.sv
// Bench for alu_result_pipe: directed scenarios on DEPTH=2/3 instances and
// randomized traffic on DEPTH=1 and DEPTH=3 against an item-level queue model.
module tb_alu_result_pipe;

  logic clk, rst_n;
  int   total, bad;

  logic        d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_zero;
  logic [31:0] d2_in_data, d2_result;
  logic [1:0]  d2_count;

  logic        d3_flush, d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_zero;
  logic [31:0] d3_in_data, d3_result;
  logic [1:0]  d3_count;

  logic        d1_flush, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_zero;
  logic [7:0]  d1_in_data, d1_result;
  logic [0:0]  d1_count;

  alu_result_pipe #(.WIDTH(32), .DEPTH(2)) u_d2 (
    .Clk(clk), .Reset(rst_n), .Flush(d2_flush), .In_Valid(d2_in_valid), .In_Ready(d2_in_ready),
    .ALUResult(d2_in_data), .Out_Valid(d2_out_valid), .Out_Ready(d2_out_ready),
    .Result(d2_result), .Result_Zero(d2_zero), .Count(d2_count));

  alu_result_pipe #(.WIDTH(32), .DEPTH(3)) u_d3 (
    .Clk(clk), .Reset(rst_n), .Flush(d3_flush), .In_Valid(d3_in_valid), .In_Ready(d3_in_ready),
    .ALUResult(d3_in_data), .Out_Valid(d3_out_valid), .Out_Ready(d3_out_ready),
    .Result(d3_result), .Result_Zero(d3_zero), .Count(d3_count));

  alu_result_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .Clk(clk), .Reset(rst_n), .Flush(d1_flush), .In_Valid(d1_in_valid), .In_Ready(d1_in_ready),
    .ALUResult(d1_in_data), .Out_Valid(d1_out_valid), .Out_Ready(d1_out_ready),
    .Result(d1_result), .Result_Zero(d1_zero), .Count(d1_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++;
    if ({d2_out_valid, d2_count, d2_result, d2_zero, d2_in_ready} !== {1'b1 ^ 1'b1, 2'd0, 32'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got ov=%0b cnt=%0d res=%h z=%0b ir=%0b, want 0 0 0 1 0",
               d2_out_valid, d2_count, d2_result, d2_zero, d2_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (d2_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_in_ready: got %0b want 1", d2_in_ready);
    end
  endtask

  task automatic test_latency();
    logic [31:0] vals [3];
    logic        eov  [5];
    logic [1:0]  ecnt [5];
    logic [31:0] eres [5];
    vals = '{32'h11, 32'h22, 32'h33};
    eov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ecnt = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
    eres = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h33};
    d2_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      d2_in_valid = (k < 3);
      d2_in_data  = (k < 3) ? vals[k] : 32'h0;
      #1;
      if (k < 3) begin
        total++;
        if (d2_in_ready !== 1'b1) begin
          bad++;
          $display("FAIL latency_in_ready k=%0d: got %0b want 1", k, d2_in_ready);
        end
      end
      @(posedge clk);
      #1;
      total++;
      if ({d2_out_valid, d2_count, d2_result} !== {eov[k], ecnt[k], eres[k]}) begin
        bad++;
        $display("FAIL latency_stream k=%0d: got ov=%0b cnt=%0d res=%h want ov=%0b cnt=%0d res=%h",
                 k, d2_out_valid, d2_count, d2_result, eov[k], ecnt[k], eres[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [4];
    logic [31:0] eres [4];
    logic [1:0]  ecnt [4];
    logic        eov  [4];
    vals = '{32'hA, 32'hB, 32'hC, 32'hD};
    eres = '{32'hB, 32'hC, 32'hD, 32'hD};
    ecnt = '{2'd3, 2'd2, 2'd1, 2'd0};
    eov  = '{1'b1, 1'b1, 1'b1, 1'b0};
    d3_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      d3_in_valid = 1'b1;
      d3_in_data  = vals[k];
      #1;
      total++;
      if (d3_in_ready !== (k < 3)) begin
        bad++;
        $display("FAIL bp_in_ready k=%0d: got %0b want %0b", k, d3_in_ready, (k < 3));
      end
      @(posedge clk);
      #1;
      total++;
      if (d3_count !== ((k < 3) ? 2'(k + 1) : 2'd3)) begin
        bad++;
        $display("FAIL bp_count k=%0d: got %0d want %0d", k, d3_count, (k < 3) ? k + 1 : 3);
      end
    end
    total++;
    if ({d3_out_valid, d3_result} !== {1'b1, 32'hA}) begin
      bad++;
      $display("FAIL bp_full_head: got ov=%0b res=%h want 1 0000000a", d3_out_valid, d3_result);
    end
    @(negedge clk);
    d3_out_ready = 1'b1;
    #1;
    total++;
    if (d3_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_in_ready: got %0b want 1", d3_in_ready);
    end
    for (int r = 0; r < 4; r++) begin
      @(posedge clk);
      #1;
      d3_in_valid = 1'b0;
      total++;
      if ({d3_out_valid, d3_count, d3_result} !== {eov[r], ecnt[r], eres[r]}) begin
        bad++;
        $display("FAIL bp_drain r=%0d: got ov=%0b cnt=%0d res=%h want ov=%0b cnt=%0d res=%h",
                 r, d3_out_valid, d3_count, d3_result, eov[r], ecnt[r], eres[r]);
      end
    end
  endtask

  task automatic test_bubble();
    logic [31:0] vals [2];
    vals = '{32'h0000_1234, 32'h0000_5678};
    @(negedge clk);
    d3_out_ready = 1'b0;
    d3_in_valid  = 1'b1;
    d3_in_data   = 32'h5A5A_5A5A;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      d3_in_valid = 1'b0;
      total++;
      if ({d3_out_valid, d3_count} !== {(e == 2), 2'd1}) begin
        bad++;
        $display("FAIL bubble_travel e=%0d: got ov=%0b cnt=%0d want ov=%0b cnt=1",
                 e, d3_out_valid, d3_count, (e == 2));
      end
    end
    total++;
    if (d3_result !== 32'h5A5A_5A5A) begin
      bad++;
      $display("FAIL bubble_head: got %h want 5a5a5a5a", d3_result);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d3_in_valid = 1'b1;
      d3_in_data  = (k < 2) ? vals[k] : 32'hFFFF_0000;
      #1;
      total++;
      if (d3_in_ready !== (k < 2)) begin
        bad++;
        $display("FAIL bubble_in_ready k=%0d: got %0b want %0b", k, d3_in_ready, (k < 2));
      end
      if (k < 2) begin
        @(posedge clk);
        #1;
        total++;
        if (d3_count !== 2'(k + 2)) begin
          bad++;
          $display("FAIL bubble_count k=%0d: got %0d want %0d", k, d3_count, k + 2);
        end
      end
    end
  endtask

  task automatic test_flush();
    d3_flush     = 1'b1;
    d3_out_ready = 1'b1;
    d3_in_valid  = 1'b1;
    #1;
    total++;
    if (d3_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_in_ready: got %0b want 0", d3_in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if ({d3_out_valid, d3_count, d3_result} !== {1'b0, 2'd0, 32'h5A5A_5A5A}) begin
      bad++;
      $display("FAIL flush_clear: got ov=%0b cnt=%0d res=%h want 0 0 5a5a5a5a",
               d3_out_valid, d3_count, d3_result);
    end
    @(negedge clk);
    d3_flush    = 1'b0;
    d3_in_valid = 1'b0;
    #1;
    total++;
    if (d3_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_after_in_ready: got %0b want 1", d3_in_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if ({d3_out_valid, d3_count} !== {1'b0, 2'd0}) begin
      bad++;
      $display("FAIL flush_stays_empty: got ov=%0b cnt=%0d want 0 0", d3_out_valid, d3_count);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] vals [2];
    vals = '{32'h77, 32'h88};
    d2_out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      d2_in_valid = 1'b1;
      d2_in_data  = vals[k];
      @(posedge clk);
    end
    @(negedge clk);
    d2_in_valid = 1'b0;
    total++;
    if ({d2_out_valid, d2_count, d2_result} !== {1'b1, 2'd2, 32'h77}) begin
      bad++;
      $display("FAIL areset_prefill: got ov=%0b cnt=%0d res=%h want 1 2 00000077",
               d2_out_valid, d2_count, d2_result);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({d2_out_valid, d2_count, d2_result, d2_zero, d2_in_ready} !== {1'b0, 2'd0, 32'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL areset_immediate: got ov=%0b cnt=%0d res=%h z=%0b ir=%0b want 0 0 0 1 0",
               d2_out_valid, d2_count, d2_result, d2_zero, d2_in_ready);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    d2_out_ready = 1'b1;
    d2_in_valid  = 1'b1;
    d2_in_data   = 32'h99;
    @(posedge clk);
    #1;
    d2_in_valid = 1'b0;
    total++;
    if ({d2_out_valid, d2_count} !== {1'b0, 2'd1}) begin
      bad++;
      $display("FAIL areset_resume_e0: got ov=%0b cnt=%0d want 0 1", d2_out_valid, d2_count);
    end
    @(posedge clk);
    #1;
    total++;
    if ({d2_out_valid, d2_count, d2_result} !== {1'b1, 2'd1, 32'h99}) begin
      bad++;
      $display("FAIL areset_resume_e1: got ov=%0b cnt=%0d res=%h want 1 1 00000099",
               d2_out_valid, d2_count, d2_result);
    end
    @(posedge clk);
    #1;
    total++;
    if ({d2_out_valid, d2_count} !== {1'b0, 2'd0}) begin
      bad++;
      $display("FAIL areset_resume_e2: got ov=%0b cnt=%0d want 0 0", d2_out_valid, d2_count);
    end
  endtask

  // Model: ordered list of in-flight items, each tagged with its stage.
  // An item advances when the stage ahead is free after the items in front moved.
  task automatic test_random(input int sel, input int depth, input int cycles);
    logic [31:0] mq [$];
    int          ms [$];
    int          ns [$];
    logic [31:0] last_out, mask, dat, obs_res;
    logic        iv, ordy, fl, leave, exp_ir, exp_ov;
    logic        obs_ir, obs_ov, obs_z;
    int          obs_cnt, bound;
    last_out = 32'h0;
    mask = (sel == 1) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      fl   = ($urandom_range(0, 49) == 0);
      dat  = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & mask);
      if (sel == 1) begin
        d1_in_valid = iv; d1_out_ready = ordy; d1_flush = fl; d1_in_data = dat[7:0];
      end else begin
        d3_in_valid = iv; d3_out_ready = ordy; d3_flush = fl; d3_in_data = dat;
      end
      #1;
      leave = (mq.size() > 0) && (ms[0] == depth - 1) && ordy;
      ns.delete();
      bound = depth;
      for (int k = 0; k < mq.size(); k++) begin
        if (k == 0 && leave) begin
          ns.push_back(depth);
        end else begin
          ns.push_back((ms[k] + 1 < bound) ? ms[k] + 1 : ms[k]);
          bound = ns[k];
        end
      end
      exp_ir = !fl && (bound > 0);
      exp_ov = (mq.size() > 0) && (ms[0] == depth - 1);
      if (sel == 1) begin
        obs_ir = d1_in_ready; obs_ov = d1_out_valid; obs_res = {24'h0, d1_result};
        obs_z = d1_zero; obs_cnt = int'(d1_count);
      end else begin
        obs_ir = d3_in_ready; obs_ov = d3_out_valid; obs_res = d3_result;
        obs_z = d3_zero; obs_cnt = int'(d3_count);
      end
      total++;
      if (obs_ir !== exp_ir) begin
        bad++;
        $display("FAIL rand%0d_in_ready c=%0d: got %0b want %0b", depth, c, obs_ir, exp_ir);
      end
      total++;
      if (obs_ov !== exp_ov) begin
        bad++;
        $display("FAIL rand%0d_out_valid c=%0d: got %0b want %0b", depth, c, obs_ov, exp_ov);
      end
      total++;
      if (obs_res !== last_out) begin
        bad++;
        $display("FAIL rand%0d_result c=%0d: got %h want %h", depth, c, obs_res, last_out);
      end
      total++;
      if (obs_z !== (last_out == 32'h0)) begin
        bad++;
        $display("FAIL rand%0d_zero c=%0d: got %0b want %0b", depth, c, obs_z, (last_out == 32'h0));
      end
      total++;
      if (obs_cnt != mq.size()) begin
        bad++;
        $display("FAIL rand%0d_count c=%0d: got %0d want %0d", depth, c, obs_cnt, mq.size());
      end
      @(posedge clk);
      if (fl) begin
        mq.delete();
        ms.delete();
      end else begin
        for (int k = 0; k < ms.size(); k++) ms[k] = ns[k];
        if (leave) begin
          void'(mq.pop_front());
          void'(ms.pop_front());
        end
        if (iv && exp_ir) begin
          mq.push_back(dat);
          ms.push_back(0);
        end
        if (mq.size() > 0 && ms[0] == depth - 1) last_out = mq[0];
      end
    end
    @(negedge clk);
    if (sel == 1) begin
      d1_in_valid = 1'b0; d1_flush = 1'b0;
    end else begin
      d3_in_valid = 1'b0; d3_flush = 1'b0;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    d2_flush = 1'b0; d2_in_valid = 1'b0; d2_out_ready = 1'b0; d2_in_data = '0;
    d3_flush = 1'b0; d3_in_valid = 1'b0; d3_out_ready = 1'b0; d3_in_data = '0;
    d1_flush = 1'b0; d1_in_valid = 1'b0; d1_out_ready = 1'b0; d1_in_data = '0;
    test_reset();
    test_latency();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random(1, 1, 10000);
    test_random(3, 3, 3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
